// File: rtl/sfp_mult_chain_if.sv
// sfp_mult_chain_if
// Groups the operand/product signals of the floating-point multiply pipeline.
//   i_req        operand pair valid this cycle
//   i_da, i_db   operands A and B, IEEE-754 binary32
//   o_vld        product valid
//   o_dat        product, IEEE-754 binary32
// master: the side that issues operands (the testbench or an upstream block).
// slave : the multiply pipeline itself.
interface sfp_mult_chain_if;
    logic        i_req;
    logic [31:0] i_da;
    logic [31:0] i_db;
    logic        o_vld;
    logic [31:0] o_dat;

    modport master (
        output i_req, i_da, i_db,
        input  o_vld, o_dat
    );

    modport slave (
        input  i_req, i_da, i_db,
        output o_vld, o_dat
    );
endinterface

// File: rtl/sfp_mult_chain.sv
// sfp_mult_chain
// Fully pipelined binary32 multiply carried out in the 26-bit short-float
// (SFP) format: [25] sign, [24:17] exponent (bias 127), [16:0] fraction.
// Four register stages, one operand pair accepted per clock:
//   stage 1  binary32 -> SFP (per operand, low 6 fraction bits dropped)
//   stage 2  18x18 mantissa product, exponent sum, special-case flags
//   stage 3  normalize, truncate, resolve specials
//   stage 4  SFP -> binary32
// Ports:
//   i_clk  system clock, rising edge
//   i_rst  asynchronous active-low reset, clears every pipeline register
//   bus    sfp_mult_chain_if.slave (i_req, i_da, i_db in; o_vld, o_dat out)
module sfp_mult_chain (
    input  logic               i_clk,
    input  logic               i_rst,
    sfp_mult_chain_if.slave    bus
);

    // ---------------- stage 1: binary32 -> SFP ----------------
    logic [25:0] slf_a;
    logic [25:0] slf_b;

    // Zero exponent (zero or denormal) flushes to signed zero.
    assign slf_a = (bus.i_da[30:23] == 8'd0) ? {bus.i_da[31], 25'd0}
                                             : {bus.i_da[31], bus.i_da[30:23], bus.i_da[22:6]};
    assign slf_b = (bus.i_db[30:23] == 8'd0) ? {bus.i_db[31], 25'd0}
                                             : {bus.i_db[31], bus.i_db[30:23], bus.i_db[22:6]};

    logic        s1_vld_a;
    logic        s1_vld_b;
    logic [25:0] s1_a;
    logic [25:0] s1_b;

    // Data registers load only with a valid pair so idle cycles keep the
    // downstream data (and therefore o_dat) at zero after reset.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s1_vld_a <= 1'b0;
            s1_vld_b <= 1'b0;
            s1_a     <= 26'd0;
            s1_b     <= 26'd0;
        end else begin
            s1_vld_a <= bus.i_req;
            s1_vld_b <= bus.i_req;
            if (bus.i_req) begin
                s1_a <= slf_a;
                s1_b <= slf_b;
            end
        end
    end

    // ---------------- stage 2: product and exponent sum ----------------
    logic       mul_req;
    logic [7:0] ea;
    logic [7:0] eb;

    assign mul_req = s1_vld_a & s1_vld_b;
    assign ea      = s1_a[24:17];
    assign eb      = s1_b[24:17];

    logic               s2_vld;
    logic               s2_sign;
    logic [35:0]        s2_p;
    logic signed [9:0]  s2_esum;
    logic               s2_a_inf;
    logic               s2_b_inf;
    logic               s2_a_zero;
    logic               s2_b_zero;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s2_vld    <= 1'b0;
            s2_sign   <= 1'b0;
            s2_p      <= 36'd0;
            s2_esum   <= 10'sd0;
            s2_a_inf  <= 1'b0;
            s2_b_inf  <= 1'b0;
            s2_a_zero <= 1'b0;
            s2_b_zero <= 1'b0;
        end else begin
            s2_vld <= mul_req;
            if (mul_req) begin
                s2_sign   <= s1_a[25] ^ s1_b[25];
                s2_p      <= {1'b1, s1_a[16:0]} * {1'b1, s1_b[16:0]};
                // 10-bit two's complement holds -127..381 without overflow.
                s2_esum   <= $signed({2'b00, ea} + {2'b00, eb} - 10'd127);
                s2_a_inf  <= (ea == 8'hFF);
                s2_b_inf  <= (eb == 8'hFF);
                s2_a_zero <= (ea == 8'h00);
                s2_b_zero <= (eb == 8'h00);
            end
        end
    end

    // ---------------- stage 3: normalize and specials ----------------
    logic               norm;
    logic [16:0]        frac;
    logic signed [9:0]  e_fin;
    logic [25:0]        mul_res;

    assign norm  = s2_p[35];
    assign frac  = norm ? s2_p[34:18] : s2_p[33:17];
    assign e_fin = s2_esum + $signed({9'd0, norm});

    always_comb begin
        mul_res = {s2_sign, e_fin[7:0], frac};
        if ((s2_a_inf && s2_b_zero) || (s2_b_inf && s2_a_zero))
            mul_res = {1'b0, 8'hFF, 17'h10000};
        else if (s2_a_inf || s2_b_inf)
            mul_res = {s2_sign, 8'hFF, 17'd0};
        else if (s2_a_zero || s2_b_zero)
            mul_res = {s2_sign, 25'd0};
        else if (e_fin >= 10'sd255)
            mul_res = {s2_sign, 8'hFF, 17'd0};
        else if (e_fin <= 10'sd0)
            mul_res = {s2_sign, 25'd0};
    end

    logic        s3_vld;
    logic [25:0] s3_res;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s3_vld <= 1'b0;
            s3_res <= 26'd0;
        end else begin
            s3_vld <= s2_vld;
            if (s2_vld)
                s3_res <= mul_res;
        end
    end

    // ---------------- stage 4: SFP -> binary32 ----------------
    logic        out_vld;
    logic [31:0] out_dat;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            out_vld <= 1'b0;
            out_dat <= 32'd0;
        end else begin
            out_vld <= s3_vld;
            if (s3_vld) begin
                if (s3_res[24:17] == 8'd0)
                    out_dat <= {s3_res[25], 31'd0};
                else
                    out_dat <= {s3_res, 6'd0};
            end
        end
    end

    assign bus.o_vld = out_vld;
    assign bus.o_dat = out_dat;

    // Truncated operand and product bits are intentionally discarded.
    logic unused_bits;
    assign unused_bits = ^{bus.i_da[5:0], bus.i_db[5:0], s2_p[16:0]};

endmodule

// File: tb/tb_sfp_mult_chain.sv
module tb_sfp_mult_chain;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sfp_mult_chain_if bus ();

    sfp_mult_chain dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Truncating SFP multiply, evaluated on binary32 fields.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int          xa = int'(a[30:23]);
        int          xb = int'(b[30:23]);
        int          e;
        logic        s = a[31] ^ b[31];
        logic [35:0] p;
        logic [16:0] f;
        if ((xa == 255 && xb == 0) || (xb == 255 && xa == 0)) return 32'h7FC00000;
        if (xa == 255 || xb == 255) return {s, 8'hFF, 23'd0};
        if (xa == 0 || xb == 0) return {s, 31'd0};
        p = 36'({1'b1, a[22:6]}) * 36'({1'b1, b[22:6]});
        e = xa + xb - 127;
        if (p[35]) begin
            f = p[34:18];
            e = e + 1;
        end else begin
            f = p[33:17];
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), f, 6'd0};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0] x;
        case ($urandom_range(0, 15))
            0:       x = 8'd0;
            1:       x = 8'd255;
            2:       x = 8'd1;
            3:       x = 8'd254;
            default: x = 8'($urandom_range(90, 165));
        endcase
        return {1'($urandom), x, 23'($urandom)};
    endfunction

    // Called at a negedge: presents one pair for a single cycle, then
    // watches o_vld across the following five rising edges.
    task automatic issue_and_watch(input string tag, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] exp);
        bus.i_req = 1'b1;
        bus.i_da  = a;
        bus.i_db  = b;
        @(negedge clk);
        bus.i_req = 1'b0;
        bus.i_da  = $urandom;
        bus.i_db  = $urandom;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 4) begin
                chk({tag, "_vld"}, {31'd0, bus.o_vld}, 32'd1);
                chk({tag, "_dat"}, bus.o_dat, exp);
            end else begin
                chk({tag, "_idle"}, {31'd0, bus.o_vld}, 32'd0);
            end
        end
    endtask

    task automatic run_one(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        issue_and_watch(tag, a, b, exp);
    endtask

    localparam int N_STREAM = 48;
    logic        hist_req [0:N_STREAM+8];
    logic [31:0] hist_exp [0:N_STREAM+8];

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        bus.i_req = 1'b0;
        bus.i_da  = 32'd0;
        bus.i_db  = 32'd0;

        // Reset state, including requests presented while held in reset.
        #12;
        chk("rst_vld", {31'd0, bus.o_vld}, 32'd0);
        chk("rst_dat", bus.o_dat, 32'd0);
        @(negedge clk);
        bus.i_req = 1'b1;
        bus.i_da  = 32'h40000000;
        bus.i_db  = 32'h40400000;
        repeat (5) @(negedge clk);
        chk("rst_hold_vld", {31'd0, bus.o_vld}, 32'd0);
        chk("rst_hold_dat", bus.o_dat, 32'd0);
        bus.i_req = 1'b0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vectors with hand-computed products.
        run_one("mul_2x3",      32'h40000000, 32'h40400000, 32'h40C00000);
        run_one("norm_1p5sq",   32'h3FC00000, 32'h3FC00000, 32'h40100000);
        run_one("sign_neg",     32'hC0000000, 32'h3F000000, 32'hBF800000);
        run_one("trunc_lsb",    32'h3F800001, 32'h3F800000, 32'h3F800000);
        run_one("trunc_keep",   32'h3F8000C0, 32'h3F800000, 32'h3F8000C0);
        run_one("zero_a",       32'h00000000, 32'h7F7FFFFF, 32'h00000000);
        run_one("neg_zero",     32'h80000000, 32'h3F800000, 32'h80000000);
        run_one("overflow",     32'h7F000000, 32'h7F000000, 32'h7F800000);
        run_one("underflow",    32'h00800000, 32'h00800000, 32'h00000000);
        run_one("nan",          32'h7F800000, 32'h00000000, 32'h7FC00000);
        run_one("nan_swap",     32'h00000000, 32'hFF800000, 32'h7FC00000);
        run_one("inf_x2",       32'h7F800000, 32'h40000000, 32'h7F800000);
        run_one("ninf_x2",      32'hFF800000, 32'h40000000, 32'hFF800000);
        run_one("e_254",        32'h7F000000, 32'h3F800000, 32'h7F000000);
        run_one("e_255",        32'h7F000000, 32'h40000000, 32'h7F800000);
        run_one("e_255_norm",   32'h7F400000, 32'h3FC00000, 32'h7F800000);
        run_one("e_1",          32'h00800000, 32'h3F800000, 32'h00800000);
        run_one("e_0",          32'h00800000, 32'h3F000000, 32'h00000000);
        run_one("denorm_flush", 32'h00400000, 32'h7F000000, 32'h00000000);

        // Streaming with gaps; outputs must mirror the request pattern 4 cycles later.
        for (int t = 0; t < N_STREAM + 6; t++) begin
            @(negedge clk);
            if (t >= 4) begin
                chk("stream_vld", {31'd0, bus.o_vld}, {31'd0, hist_req[t-4]});
                if (hist_req[t-4])
                    chk("stream_dat", bus.o_dat, hist_exp[t-4]);
            end
            if (t < N_STREAM) begin
                a = rand_op();
                b = rand_op();
                hist_req[t] = ((t % 7) != 5);
                hist_exp[t] = ref_mul(a, b);
                bus.i_req   = hist_req[t];
                bus.i_da    = a;
                bus.i_db    = b;
            end else begin
                hist_req[t] = 1'b0;
                hist_exp[t] = 32'd0;
                bus.i_req   = 1'b0;
            end
        end

        // Reset with operations in flight.
        @(negedge clk);
        bus.i_req = 1'b1;
        bus.i_da  = 32'h3FC00000;
        bus.i_db  = 32'h3FC00000;
        @(negedge clk);
        bus.i_da  = 32'h40000000;
        bus.i_db  = 32'h40000000;
        @(negedge clk);
        bus.i_da  = 32'hC0000000;
        bus.i_db  = 32'h40400000;
        @(negedge clk);
        bus.i_req = 1'b0;
        chk("flight_pre_vld", {31'd0, bus.o_vld}, 32'd0);
        @(negedge clk);
        chk("flight_first_vld", {31'd0, bus.o_vld}, 32'd1);
        chk("flight_first_dat", bus.o_dat, 32'h40100000);
        rst = 1'b0;
        #1;
        chk("mid_rst_vld", {31'd0, bus.o_vld}, 32'd0);
        chk("mid_rst_dat", bus.o_dat, 32'd0);
        @(negedge clk);
        bus.i_req = 1'b1;
        bus.i_da  = 32'h41000000;
        bus.i_db  = 32'h41000000;
        @(negedge clk);
        chk("mid_rst_hold_vld", {31'd0, bus.o_vld}, 32'd0);
        chk("mid_rst_hold_dat", bus.o_dat, 32'd0);
        // Release together with a new request; it is the first one accepted.
        rst = 1'b1;
        issue_and_watch("post_rst", 32'h40000000, 32'h40400000, 32'h40C00000);
        chk("post_rst_dat_hold", bus.o_dat, 32'h40C00000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
